// File: rtl/unscaling.sv
// Quad unscaling: X * GAIN_X and Y * GAIN_Y (Q2.18) through one shared multiplier, Z passes through.
// Optional build macro UNSCALE_ROUND_EN selects round-half-up instead of floor truncation.
module unscaling #(
  parameter logic [20:0] GAIN_X = 21'h33333,
  parameter logic [20:0] GAIN_Y = 21'h44444
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [20:0] vtx1_X_scaled,
  input  logic [20:0] vtx1_Y_scaled,
  input  logic [20:0] vtx1_Z_scaled,
  input  logic [20:0] vtx2_X_scaled,
  input  logic [20:0] vtx2_Y_scaled,
  input  logic [20:0] vtx2_Z_scaled,
  input  logic [20:0] vtx3_X_scaled,
  input  logic [20:0] vtx3_Y_scaled,
  input  logic [20:0] vtx3_Z_scaled,
  input  logic [20:0] vtx4_X_scaled,
  input  logic [20:0] vtx4_Y_scaled,
  input  logic [20:0] vtx4_Z_scaled,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [20:0] vtx1_X_raw,
  output logic [20:0] vtx1_Y_raw,
  output logic [20:0] vtx1_Z_raw,
  output logic [20:0] vtx2_X_raw,
  output logic [20:0] vtx2_Y_raw,
  output logic [20:0] vtx2_Z_raw,
  output logic [20:0] vtx3_X_raw,
  output logic [20:0] vtx3_Y_raw,
  output logic [20:0] vtx3_Z_raw,
  output logic [20:0] vtx4_X_raw,
  output logic [20:0] vtx4_Y_raw,
  output logic [20:0] vtx4_Z_raw
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // a valid quad is held stable until it is accepted.

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

`ifdef UNSCALE_ROUND_EN
  localparam logic signed [41:0] RND_ADD = 42'sd131072;
`else
  localparam logic signed [41:0] RND_ADD = 42'sd0;
`endif
  localparam logic signed [41:0] SAT_MAX = 42'sd1048575;
  localparam logic signed [41:0] SAT_MIN = -42'sd1048576;

  state_t state_q, state_d;
  logic [3:0] step_q, step_d;
  logic signed [20:0] hold_x_q [4];
  logic signed [20:0] hold_y_q [4];
  logic signed [20:0] hold_z_q [4];
  logic signed [20:0] hold_x_d [4];
  logic signed [20:0] hold_y_d [4];
  logic signed [20:0] hold_z_d [4];
  logic signed [20:0] out_x_q [4];
  logic signed [20:0] out_y_q [4];
  logic signed [20:0] out_z_q [4];
  logic signed [20:0] out_x_d [4];
  logic signed [20:0] out_y_d [4];
  logic signed [20:0] out_z_d [4];
  logic signed [41:0] prod_q, prod_d;
  logic [2:0] prod_idx_q, prod_idx_d;
  logic prod_vld_q, prod_vld_d;

  logic signed [20:0] in_x [4];
  logic signed [20:0] in_y [4];
  logic signed [20:0] in_z [4];
  logic signed [20:0] coord_sel;
  logic signed [20:0] gain_sel;
  logic signed [41:0] coord_ext;
  logic signed [41:0] gain_ext;
  logic signed [41:0] p_adj;
  logic signed [41:0] r_shift;
  logic signed [20:0] r_sat;

  assign in_x[0] = vtx1_X_scaled;
  assign in_x[1] = vtx2_X_scaled;
  assign in_x[2] = vtx3_X_scaled;
  assign in_x[3] = vtx4_X_scaled;
  assign in_y[0] = vtx1_Y_scaled;
  assign in_y[1] = vtx2_Y_scaled;
  assign in_y[2] = vtx3_Y_scaled;
  assign in_y[3] = vtx4_Y_scaled;
  assign in_z[0] = vtx1_Z_scaled;
  assign in_z[1] = vtx2_Z_scaled;
  assign in_z[2] = vtx3_Z_scaled;
  assign in_z[3] = vtx4_Z_scaled;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Step counter walks 0..7 issuing v1X,v1Y..v4Y into the registered product; step 8 drains it.
  always_comb begin
    coord_sel = step_q[0] ? hold_y_q[step_q[2:1]] : hold_x_q[step_q[2:1]];
    gain_sel  = step_q[0] ? $signed(GAIN_Y) : $signed(GAIN_X);
    coord_ext = {{21{coord_sel[20]}}, coord_sel};
    gain_ext  = {{21{gain_sel[20]}}, gain_sel};
    prod_d    = coord_ext * gain_ext;

    p_adj   = prod_q + RND_ADD;
    r_shift = p_adj >>> 18;
    if (r_shift > SAT_MAX) begin
      r_sat = 21'sh0FFFFF;
    end else if (r_shift < SAT_MIN) begin
      r_sat = 21'sh100000;
    end else begin
      r_sat = r_shift[20:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    hold_x_d   = hold_x_q;
    hold_y_d   = hold_y_q;
    hold_z_d   = hold_z_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    out_z_d    = out_z_q;
    prod_vld_d = (state_q == CALC) && !step_q[3];
    prod_idx_d = step_q[2:0];

    if (prod_vld_q) begin
      if (prod_idx_q[0]) begin
        out_y_d[prod_idx_q[2:1]] = r_sat;
      end else begin
        out_x_d[prod_idx_q[2:1]] = r_sat;
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hold_x_d = in_x;
          hold_y_d = in_y;
          hold_z_d = in_z;
          step_d   = 4'd0;
          state_d  = CALC;
        end
      end
      CALC: begin
        step_d = step_q + 4'd1;
        if (step_q == 4'd8) begin
          out_z_d = hold_z_q;
          step_d  = 4'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= 4'd0;
      prod_q     <= '0;
      prod_idx_q <= 3'd0;
      prod_vld_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hold_x_q[i] <= '0;
        hold_y_q[i] <= '0;
        hold_z_q[i] <= '0;
        out_x_q[i]  <= '0;
        out_y_q[i]  <= '0;
        out_z_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      prod_q     <= prod_d;
      prod_idx_q <= prod_idx_d;
      prod_vld_q <= prod_vld_d;
      hold_x_q   <= hold_x_d;
      hold_y_q   <= hold_y_d;
      hold_z_q   <= hold_z_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      out_z_q    <= out_z_d;
    end
  end

  assign vtx1_X_raw = out_x_q[0];
  assign vtx2_X_raw = out_x_q[1];
  assign vtx3_X_raw = out_x_q[2];
  assign vtx4_X_raw = out_x_q[3];
  assign vtx1_Y_raw = out_y_q[0];
  assign vtx2_Y_raw = out_y_q[1];
  assign vtx3_Y_raw = out_y_q[2];
  assign vtx4_Y_raw = out_y_q[3];
  assign vtx1_Z_raw = out_z_q[0];
  assign vtx2_Z_raw = out_z_q[1];
  assign vtx3_Z_raw = out_z_q[2];
  assign vtx4_Z_raw = out_z_q[3];

endmodule

// File: tb/tb_unscaling.sv
// Bench for unscaling: directed quads with hand-computed results, scoreboard queue checked by a monitor.
// Expected values follow the UNSCALE_ROUND_EN build setting.
module tb_unscaling;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [3:0][20:0] ix, iy, iz;
  logic [3:0][20:0] ox, oy, oz;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [251:0] exp_q[$];
  int  hs_cyc = 0;
  bit  pending = 1'b0;
  bit  ov_prev = 1'b0;

  unscaling dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .vtx1_X_scaled(ix[0]), .vtx1_Y_scaled(iy[0]), .vtx1_Z_scaled(iz[0]),
    .vtx2_X_scaled(ix[1]), .vtx2_Y_scaled(iy[1]), .vtx2_Z_scaled(iz[1]),
    .vtx3_X_scaled(ix[2]), .vtx3_Y_scaled(iy[2]), .vtx3_Z_scaled(iz[2]),
    .vtx4_X_scaled(ix[3]), .vtx4_Y_scaled(iy[3]), .vtx4_Z_scaled(iz[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .vtx1_X_raw(ox[0]), .vtx1_Y_raw(oy[0]), .vtx1_Z_raw(oz[0]),
    .vtx2_X_raw(ox[1]), .vtx2_Y_raw(oy[1]), .vtx2_Z_raw(oz[1]),
    .vtx3_X_raw(ox[2]), .vtx3_Y_raw(oy[2]), .vtx3_Z_raw(oz[2]),
    .vtx4_X_raw(ox[3]), .vtx4_Y_raw(oy[3]), .vtx4_Z_raw(oz[3])
  );

  // ---------------- helpers ----------------
  function automatic logic [3:0][20:0] q4(input int a, input int b, input int c, input int d);
    logic [3:0][20:0] r;
    r[0] = a[20:0];
    r[1] = b[20:0];
    r[2] = c[20:0];
    r[3] = d[20:0];
    return r;
  endfunction

  function automatic logic signed [31:0] sx(input logic [20:0] v);
    return {{11{v[20]}}, v};
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Compares all twelve output coordinates against a packed {z,y,x} expectation.
  task automatic chk_quad(input string tag, input logic [251:0] req);
    logic [251:0] act;
    string axis;
    act = {oz, oy, ox};
    for (int k = 0; k < 12; k++) begin
      axis = (k < 4) ? "X" : ((k < 8) ? "Y" : "Z");
      chk($sformatf("%s_v%0d%s", tag, (k % 4) + 1, axis), sx(act[21*k +: 21]), sx(req[21*k +: 21]));
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      pending = 1'b0;
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        hs_cyc  = cyc + 1;
        pending = 1'b1;
      end
      if (out_valid && !ov_prev && pending) begin
        chk("latency", cyc - hs_cyc, 9);
        pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=handshake required=none");
        end else begin
          chk_quad("out", exp_q.pop_front());
        end
      end
      ov_prev = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_quad(input logic [3:0][20:0] x, input logic [3:0][20:0] y,
                            input logic [3:0][20:0] z);
    bit got;
    @(posedge clk); #1;
    ix = x; iy = y; iz = z;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL in_handshake_timeout actual=no_ready required=ready");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int bound);
    bit got;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout actual=0 required=1");
    end
  endtask

  task automatic wait_drain(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    chk_quad(tag, '0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0][20:0] ex, ey;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ix = '0; iy = '0; iz = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ix = {$urandom, $urandom, $urandom};
      iy = {$urandom, $urandom, $urandom};
      iz = {$urandom, $urandom, $urandom};
      in_valid = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    // Basic quad, then mixed negative/saturating quad back to back.
`ifdef UNSCALE_ROUND_EN
    ex = q4(256, 0, 0, 0); ey = q4(256, 0, 0, 0);
`else
    ex = q4(255, 0, 0, 0); ey = q4(255, 0, 0, 0);
`endif
    exp_q.push_back({q4(77, 0, 0, 0), ey, ex});
    drive_quad(q4(320, 0, 0, 0), q4(240, 0, 0, 0), q4(77, 0, 0, 0));

    ex = q4(0, -256, 838859, 0);
    ey = q4(0, 0, 1048575, -1048576);
    exp_q.push_back({q4(-5, 100, 0, -1048576), ey, ex});
    drive_quad(q4(0, -320, 1048575, 0), q4(0, 0, 1048575, -1048576), q4(-5, 100, 0, -1048576));
    wait_drain(60);

    // Backpressure: hold in DONE for 20 cycles while new input traffic is offered.
    @(posedge clk); #1;
    out_ready = 1'b0;
`ifdef UNSCALE_ROUND_EN
    ex = q4(800, -800, 4, -4); ey = q4(107, -107, 7, 0);
`else
    ex = q4(799, -800, 3, -4); ey = q4(106, -107, 7, 0);
`endif
    exp_q.push_back({q4(1, 2, 3, 4), ey, ex});
    drive_quad(q4(1000, -1000, 5, -5), q4(100, -100, 7, 0), q4(1, 2, 3, 4));
    wait_out_valid(30);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      ix = {$urandom, $urandom, $urandom};
      iy = {$urandom, $urandom, $urandom};
      iz = {$urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      chk("bp_out_valid", {31'd0, out_valid}, 1);
      if (exp_q.size() > 0) chk_quad("bp_hold", exp_q[0]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_in_ready", {31'd0, in_ready}, 1);
    chk("bp_after_out_valid", {31'd0, out_valid}, 0);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset while the multiplier is on step 4; the partial quad must vanish.
    drive_quad(q4(320, 320, 320, 320), q4(240, 240, 240, 240), q4(7, 7, 7, 7));
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("abort");
    repeat (15) @(negedge clk);
    chk("abort_no_out_valid", {31'd0, out_valid}, 0);

    // Recovery quad after the abort.
`ifdef UNSCALE_ROUND_EN
    ex = q4(-1, 1, 0, 0); ey = q4(-1, 1, 0, 0);
`else
    ex = q4(-1, 0, 0, 0); ey = q4(-2, 1, 0, 0);
`endif
    exp_q.push_back({q4(9, 9, 9, 9), ey, ex});
    drive_quad(q4(-1, 1, 0, 0), q4(-1, 1, 0, 0), q4(9, 9, 9, 9));
    wait_drain(60);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
